keypad_encoder_n: RTL and testbench

- Parametrised successor to the microwave keypad encoder.
- Takes an N-key keypad and produces a registered binary key code, an active-low load flag and a single-cycle program/count pulse.
- Adds priority encoding, a counter-based debounce, press and release debounce, and auto-repeat of a held key.
- Keeps the existing mode mux: pgt carries key strobes while enabled, and a free-running divider tick while disabled.
- Sits between the keypad pins and the timer/BCD counter chain.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_encoder_n_tick_divider.sv | 30 +++
 rtl/keypad_encoder_n.sv | 162 ++++++++++++++++
 tb/tb_keypad_encoder_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad encoder family.
// Pure declarations: no latency, no flow control.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } kp_state_t;

   localparam int MAX_KEYS = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Lowest set index wins; an all-zero vector encodes as 0.
   function automatic int prio_enc(input logic [MAX_KEYS-1:0] v);
      int r;
      r = 0;
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_encoder_n_tick_divider.sv
// Free-running divide-by-TICK_DIV pulse generator; tick is one registered cycle per period.
// tick_next is the combinational decode one cycle ahead of tick; no backpressure.
module tick_divider
   import keypad_pkg::*;
#(
   parameter int TICK_DIV = 100
) (
   input  logic clk,
   input  logic reset,
   output logic tick,
   output logic tick_next
);

   localparam int W = clog2(TICK_DIV);

   logic [W-1:0] divcnt;

   assign tick_next = (divcnt == W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         divcnt <= '0;
         tick   <= 1'b0;
      end else begin
         tick   <= tick_next;
         divcnt <= tick_next ? '0 : divcnt + W'(1);
      end
   end

endmodule

// File: rtl/keypad_encoder_n.sv
// N-key priority encoder with press/release debounce, auto-repeat and timer-mode pgt mux.
// D/loadn settle DEBOUNCE_CYCLES edges after key_q, pgt one edge later; no backpressure.
module keypad_encoder_n
   import keypad_pkg::*;
#(
   parameter int NUM_KEYS        = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 100,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_RATE     = 50
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key,
   input  logic                enablen,
   output logic [CODE_W-1:0]   D,
   output logic                loadn,
   output logic                pgt,
   output logic                tick,
   output logic                multi
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = clog2(RPT_MAX + 1);
   localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

   logic [NUM_KEYS-1:0] key_q;
   logic [MAX_KEYS-1:0] key_ext;
   logic [CODE_W-1:0]   code, cand, cand_n, d_n;
   logic                any, loadn_n, strobe, strobe_n, tick_next;
   logic                primed, armed, armed_n, rep_on, rep_on_n;
   logic [7:0]          cnt, cnt_n;
   logic [RPT_W-1:0]    rpt, rpt_n, rpt_inc, rpt_target;
   kp_state_t           state, state_n;

   assign key_ext    = MAX_KEYS'(key_q);
   assign code       = CODE_W'(prio_enc(key_ext));
   assign any        = |key_q;
   assign rpt_inc    = rpt + RPT_W'(1);
   assign rpt_target = rep_on ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);

   tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .tick_next (tick_next)
   );

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      cnt_n    = cnt;
      rpt_n    = rpt;
      rep_on_n = rep_on;
      d_n      = D;
      loadn_n  = loadn;
      strobe_n = 1'b0;
      // A key already down when we come out of reset must be seen released first.
      armed_n  = armed | (primed & ~any);
      case (state)
         IDLE: begin
            if (!enablen && any && armed) begin
               cand_n = code;
               cnt_n  = 8'd1;
               if (DB == 8'd1) begin
                  state_n  = PRESSED;
                  d_n      = code;
                  loadn_n  = 1'b0;
                  strobe_n = 1'b1;
                  rpt_n    = '0;
                  rep_on_n = 1'b0;
               end else begin
                  state_n = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (any && code == cand) begin
               cnt_n = cnt + 8'd1;
               if (cnt + 8'd1 == DB) begin
                  state_n  = PRESSED;
                  d_n      = cand;
                  loadn_n  = 1'b0;
                  strobe_n = 1'b1;
                  rpt_n    = '0;
                  rep_on_n = 1'b0;
               end
            end else begin
               state_n = IDLE;
            end
         end
         PRESSED: begin
            if (!any) begin
               cnt_n = 8'd1;
               if (DB == 8'd1) begin
                  state_n = IDLE;
                  loadn_n = 1'b1;
               end else begin
                  state_n = RELEASE;
               end
            end else if (REPEAT_DELAY > 0 && rpt_inc == rpt_target) begin
               strobe_n = 1'b1;
               rpt_n    = '0;
               rep_on_n = 1'b1;
            end else begin
               rpt_n = rpt_inc;
            end
         end
         RELEASE: begin
            if (!any) begin
               cnt_n = cnt + 8'd1;
               if (cnt + 8'd1 == DB) begin
                  state_n = IDLE;
                  loadn_n = 1'b1;
               end
            end else begin
               state_n = PRESSED;
            end
         end
         default: state_n = IDLE;
      endcase
      if (enablen) begin
         state_n  = IDLE;
         loadn_n  = 1'b1;
         strobe_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_q  <= '0;
         multi  <= 1'b0;
         state  <= IDLE;
         cand   <= '0;
         cnt    <= '0;
         rpt    <= '0;
         rep_on <= 1'b0;
         D      <= '0;
         loadn  <= 1'b1;
         strobe <= 1'b0;
         pgt    <= 1'b0;
         primed <= 1'b0;
         armed  <= 1'b0;
      end else begin
         key_q  <= key;
         multi  <= |(key_q & (key_q - NUM_KEYS'(1)));
         state  <= state_n;
         cand   <= cand_n;
         cnt    <= cnt_n;
         rpt    <= rpt_n;
         rep_on <= rep_on_n;
         D      <= d_n;
         loadn  <= loadn_n;
         strobe <= strobe_n;
         pgt    <= enablen ? tick_next : strobe;
         primed <= 1'b1;
         armed  <= armed_n;
      end
   end

endmodule

// File: tb/tb_keypad_encoder_n.sv
// Directed bench for keypad_encoder_n: a default instance plus an auto-repeat instance.
// Both share stimulus; outputs sampled 1 ns after each rising edge.
module tb_keypad_encoder_n;

   logic       clk;
   logic       reset;
   logic [9:0] key;
   logic       enablen;
   logic [3:0] D, D2;
   logic       loadn, pgt, tick, multi;
   logic       loadn2, pgt2, tick2, multi2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int np    = 0;
   int c0;
   int pq[$];
   int tq[$];
   int gq[$];

   keypad_encoder_n dut (
      .clk(clk), .reset(reset), .key(key), .enablen(enablen),
      .D(D), .loadn(loadn), .pgt(pgt), .tick(tick), .multi(multi)
   );

   keypad_encoder_n #(.REPEAT_DELAY(20), .REPEAT_RATE(5)) dut_rpt (
      .clk(clk), .reset(reset), .key(key), .enablen(enablen),
      .D(D2), .loadn(loadn2), .pgt(pgt2), .tick(tick2), .multi(multi2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (pgt) np++;
         if (pgt2) pq.push_back(cyc);
      end
   endtask

   initial begin
      int t2n;
      int lowc;
      reset = 1'b1; key = '0; enablen = 1'b0;
      step(2);
      check("rst_D", D, 0);
      check("rst_loadn", loadn, 1);
      check("rst_pgt", pgt, 0);
      check("rst_tick", tick, 0);
      check("rst_multi", multi, 0);
      reset = 1'b0;
      step(3);

      // Test 1: single key 3
      np = 0;
      key = 10'b0000001000;
      step(4);
      check("t1_loadn_early", loadn, 1);
      step(1);
      check("t1_D", D, 3);
      check("t1_loadn", loadn, 0);
      check("t1_pgt_early", pgt, 0);
      step(1);
      check("t1_pgt", pgt, 1);
      step(4);
      check("t1_npulse", np, 1);
      check("t1_multi", multi, 0);
      key = '0;
      step(4);
      check("t1_rel_early", loadn, 0);
      step(1);
      check("t1_rel", loadn, 1);
      check("t1_D_hold", D, 3);
      step(2);

      // Test 2: bounce on key 5
      np = 0;
      key = 10'b0000100000;
      step(3);
      key = '0;
      step(1);
      check("t2_no_acc1", loadn, 1);
      key = 10'b0000100000;
      step(3);
      check("t2_no_acc2", loadn, 1);
      step(1);
      check("t2_no_acc3", loadn, 1);
      step(1);
      check("t2_D", D, 5);
      check("t2_loadn", loadn, 0);
      step(1);
      key = '0;
      step(8);
      check("t2_npulse", np, 1);
      check("t2_rel", loadn, 1);
      step(2);

      // Test 3: keys 2 and 7 together, then drop 2
      np = 0;
      key = 10'b0010000100;
      step(2);
      check("t3_multi", multi, 1);
      step(3);
      check("t3_D", D, 2);
      check("t3_loadn", loadn, 0);
      key = 10'b0010000000;
      step(5);
      check("t3_D_hold", D, 2);
      check("t3_multi_drop", multi, 0);
      check("t3_npulse", np, 1);
      key = '0;
      step(4);
      check("t3_rel_early", loadn, 0);
      step(1);
      check("t3_rel", loadn, 1);
      step(2);

      // Test 4: auto-repeat on key 9
      np = 0;
      pq.delete();
      c0 = cyc;
      key = 10'b1000000000;
      step(20);
      check("t4_D2", D2, 9);
      check("t4_loadn2", loadn2, 0);
      check("t4_multi2", multi2, 0);
      step(20);
      key = '0;
      step(20);
      check("t4_rpt_count", pq.size(), 5);
      for (int k = 0; k < 5; k++) begin
         int exp_off[5];
         exp_off = '{6, 26, 31, 36, 41};
         check($sformatf("t4_rpt_at%0d", k), (k < pq.size()) ? pq[k] - c0 : -1, exp_off[k]);
      end
      check("t4_main_npulse", np, 1);
      check("t4_rel2", loadn2, 1);

      // Test 6: reset mid-debounce and mid-press on key 4
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(2);
      np = 0;
      key = 10'b0000010000;
      step(2);
      reset = 1'b1;
      step(1);
      check("t6a_D", D, 0);
      check("t6a_loadn", loadn, 1);
      check("t6a_pgt", pgt, 0);
      check("t6a_multi", multi, 0);
      reset = 1'b0;
      step(10);
      check("t6a_held_loadn", loadn, 1);
      check("t6a_held_np", np, 0);
      key = '0;
      step(3);
      key = 10'b0000010000;
      step(5);
      check("t6b_D", D, 4);
      check("t6b_loadn", loadn, 0);
      step(1);
      check("t6b_np", np, 1);
      reset = 1'b1;
      step(1);
      check("t6c_D", D, 0);
      check("t6c_loadn", loadn, 1);
      check("t6c_pgt", pgt, 0);
      reset = 1'b0;
      step(10);
      check("t6c_held_loadn", loadn, 1);
      check("t6c_held_np", np, 1);
      key = '0;
      step(3);
      key = 10'b0000010000;
      step(5);
      check("t6d_D", D, 4);
      check("t6d_loadn", loadn, 0);
      key = '0;
      step(6);

      // Test 5: timer mode
      reset = 1'b1; enablen = 1'b1; key = '0;
      step(1);
      reset = 1'b0;
      t2n = 0;
      lowc = 0;
      tq.delete();
      gq.delete();
      for (int i = 1; i <= 350; i++) begin
         key = ((i >= 10 && i < 60) || (i >= 150 && i < 170)) ? 10'b0000010000 : 10'b0;
         step(1);
         if (tick) tq.push_back(i);
         if (pgt) gq.push_back(i);
         if (tick2) t2n++;
         if (!loadn) lowc++;
      end
      check("t5_tick_count", tq.size(), 3);
      check("t5_pgt_count", gq.size(), 3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t5_tick_at%0d", k), (k < tq.size()) ? tq[k] : -1, 100 * (k + 1));
         check($sformatf("t5_pgt_at%0d", k), (k < gq.size()) ? gq[k] : -1, 100 * (k + 1));
      end
      check("t5_tick2_count", t2n, 3);
      check("t5_loadn_low", lowc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
